// File: rtl/mau_pkg.sv
// mau_pkg: shared definitions for the memory access unit.
//   - request size encodings (SZ_*)
//   - bus direction constants for memory_rw (READ / WRITE)
//   - FSM state enumeration
//   - access legality check used at request accept
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR       = 3'd3,
        ST_RMW_RD   = 3'd4,
        ST_RMW_DATA = 3'd5,
        ST_RMW_WR   = 3'd6
    } state_e;

    // True when the request must be rejected: reserved size, odd halfword
    // address, or word address not on a 4-byte boundary.
    function automatic logic is_bad_access(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane steering.
//   Load path : picks the addressed byte/half of rd_word and sign- or
//               zero-extends it to 32 bits (word passes through).
//   Store path: replaces the addressed byte/half of rd_word with the low
//               bits of wr_src; a word access takes wr_src whole.
// Ports:
//   addr_lo     in  2   byte offset within the word
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned in  1   zero-extend loads when 1
//   rd_word     in  32  word read from memory
//   wr_src      in  32  right-aligned store data
//   load_data   out 32  formatted load result
//   merged_word out 32  word to write back
module mem_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_src,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0] rd_byte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] lane_src;

            assign rd_byte[gi] = rd_word[8*gi +: 8];

            // A byte store hits one lane; a half store hits the two lanes of
            // the addressed half and feeds them from wr_src[15:0].
            always_comb begin
                lane_hit = 1'b0;
                lane_src = wr_src[8*gi +: 8];
                case (size)
                    SZ_BYTE: begin
                        lane_hit = (addr_lo == LANE);
                        lane_src = wr_src[7:0];
                    end
                    SZ_HALF: begin
                        lane_hit = (addr_lo[1] == LANE[1]);
                        lane_src = wr_src[8*(gi%2) +: 8];
                    end
                    SZ_WORD: lane_hit = 1'b1;
                    default: lane_hit = 1'b0;
                endcase
            end

            assign merged_word[8*gi +: 8] = lane_hit ? lane_src : rd_byte[gi];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rd_byte[addr_lo];
        sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
            SZ_HALF: load_data = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns CPU load/store requests into word accesses on the
// data-memory bus. One request in flight; sub-word stores are done as a
// read-modify-write so memory only ever sees whole words.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (taken on both high at edge)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                request fields, sampled only on the accept edge
//   rsp_valid, rsp_err,
//   rsp_rdata                one-cycle completion pulse with status/data
//   memory_addr, memory_as_,
//   memory_rw, memory_wr_data,
//   memory_rd_data           word-addressed memory bus (strobe active-low,
//                            read data valid the cycle after a read strobe)
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_AW = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [MEM_AW+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [MEM_AW-1:0] memory_addr,
    output logic              memory_as_,
    output logic              memory_rw,
    output logic [31:0]       memory_wr_data,
    input  logic [31:0]       memory_rd_data
);

    state_e            state_q,     state_d;
    logic [MEM_AW+1:0] addr_q,      addr_d;
    logic [1:0]        size_q,      size_d;
    logic              unsigned_q,  unsigned_d;
    // Holds the store data from accept; for sub-word stores it is replaced by
    // the merged word in RMW_DATA so the write strobe can drive it directly.
    logic [31:0]       wdata_q,     wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    mem_lane_align u_align (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .rd_word     (memory_rd_data),
        .wr_src      (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign req_ready = (state_q == ST_IDLE) & ~rst;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d     = req_addr;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    if (is_bad_access(req_size, req_addr[1:0])) begin
                        // Rejected without touching the bus.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!req_we) begin
                        state_d = ST_RD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD:      state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data;
                state_d     = ST_IDLE;
            end
            ST_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_RMW_RD:  state_d = ST_RMW_DATA;
            ST_RMW_DATA: begin
                wdata_d = merged_word;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Bus strobes decode straight from the state register, so they occupy
    // exactly the cycle spent in the strobe state.
    always_comb begin
        memory_as_ = 1'b1;
        memory_rw  = READ;
        case (state_q)
            ST_RD, ST_RMW_RD: begin
                memory_as_ = 1'b0;
                memory_rw  = READ;
            end
            ST_WR, ST_RMW_WR: begin
                memory_as_ = 1'b0;
                memory_rw  = WRITE;
            end
            default: begin
                memory_as_ = 1'b1;
                memory_rw  = READ;
            end
        endcase
    end

    assign memory_addr    = addr_q[MEM_AW+1:2];
    assign memory_wr_data = wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_rdata      = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a small behavioural memory
// that responds to the bus and counts read/write strobes.
module tb_mem_access_unit;

    localparam int MEM_AW = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [MEM_AW+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [MEM_AW-1:0] memory_addr;
    logic              memory_as_;
    logic              memory_rw;
    logic [31:0]       memory_wr_data;
    logic [31:0]       memory_rd_data;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_AW(MEM_AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .rsp_rdata      (rsp_rdata),
        .memory_addr    (memory_addr),
        .memory_as_     (memory_as_),
        .memory_rw      (memory_rw),
        .memory_wr_data (memory_wr_data),
        .memory_rd_data (memory_rd_data)
    );

    // Memory model: 64 words, read data registered one cycle after strobe.
    logic [31:0] mem [64];
    int rd_cnt = 0;
    int wr_cnt = 0;

    always @(posedge clk) begin
        if (memory_as_ === 1'b0) begin
            if (memory_rw === 1'b1) begin
                memory_rd_data <= mem[memory_addr[5:0]];
                rd_cnt <= rd_cnt + 1;
            end else begin
                mem[memory_addr[5:0]] <= memory_wr_data;
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single accept edge; returns in cycle T+1.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid    = 1'b0;
        req_wdata    = 32'hDEAD_BEEF;
    endtask

    task automatic word_store(input logic [31:0] addr, input logic [31:0] data);
        issue(1'b1, 2'b10, 1'b0, addr, data);
        n_cmp++; if (memory_as_ !== 1'b0 || memory_rw !== 1'b0) begin n_mis++;
            $display("FAIL wst_strobe: as_=%b rw=%b required 0/0", memory_as_, memory_rw); end
        n_cmp++; if (memory_addr !== 30'(addr >> 2)) begin n_mis++;
            $display("FAIL wst_addr: got %h required %h", memory_addr, addr >> 2); end
        n_cmp++; if (memory_wr_data !== data) begin n_mis++;
            $display("FAIL wst_wdata: got %h required %h", memory_wr_data, data); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin n_mis++;
            $display("FAIL wst_rsp: valid=%b err=%b rdata=%h required 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        n_cmp++; if (mem[addr[7:2]] !== data) begin n_mis++;
            $display("FAIL wst_mem: got %h required %h", mem[addr[7:2]], data); end
        $display("word store addr=%h data=%h", addr, data);
    endtask

    task automatic do_load(input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, size, uns, addr, 32'h0);
        n_cmp++; if (memory_as_ !== 1'b0 || memory_rw !== 1'b1 || memory_addr !== 30'(addr >> 2)) begin n_mis++;
            $display("FAIL ld_strobe: as_=%b rw=%b addr=%h required 0/1/%h", memory_as_, memory_rw, memory_addr, addr >> 2); end
        tick();
        n_cmp++; if (memory_as_ !== 1'b1 || rsp_valid !== 1'b0) begin n_mis++;
            $display("FAIL ld_data_cycle: as_=%b rsp_valid=%b required 1/0", memory_as_, rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp) begin n_mis++;
            $display("FAIL ld_rsp: valid=%b err=%b rdata=%h required 1/0/%h", rsp_valid, rsp_err, rsp_rdata, exp); end
        $display("load size=%0d uns=%b addr=%h rdata=%h", size, uns, addr, rsp_rdata);
    endtask

    task automatic sub_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_word);
        int rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(1'b1, size, 1'b0, addr, wdata);
        n_cmp++; if (memory_as_ !== 1'b0 || memory_rw !== 1'b1) begin n_mis++;
            $display("FAIL rmw_rd: as_=%b rw=%b required 0/1", memory_as_, memory_rw); end
        tick();
        n_cmp++; if (memory_as_ !== 1'b1) begin n_mis++;
            $display("FAIL rmw_merge: as_=%b required 1", memory_as_); end
        tick();
        n_cmp++; if (memory_as_ !== 1'b0 || memory_rw !== 1'b0 || memory_wr_data !== exp_word) begin n_mis++;
            $display("FAIL rmw_wr: as_=%b rw=%b wdata=%h required 0/0/%h", memory_as_, memory_rw, memory_wr_data, exp_word); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin n_mis++;
            $display("FAIL rmw_rsp: valid=%b err=%b rdata=%h required 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        n_cmp++; if (mem[addr[7:2]] !== exp_word) begin n_mis++;
            $display("FAIL rmw_mem: got %h required %h", mem[addr[7:2]], exp_word); end
        n_cmp++; if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1) begin n_mis++;
            $display("FAIL rmw_strobes: reads=%0d writes=%0d required 1/1", rd_cnt - rd0, wr_cnt - wr0); end
        $display("sub-word store size=%0d addr=%h wdata=%h word=%h", size, addr, wdata, mem[addr[7:2]]);
    endtask

    task automatic bad_req(input logic we, input logic [1:0] size, input logic [31:0] addr);
        int rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(we, size, 1'b0, addr, 32'h1234_5678);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin n_mis++;
            $display("FAIL err_rsp: valid=%b err=%b rdata=%h required 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        n_cmp++; if (memory_as_ !== 1'b1 || req_ready !== 1'b1) begin n_mis++;
            $display("FAIL err_bus: as_=%b ready=%b required 1/1", memory_as_, req_ready); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || rd_cnt != rd0 || wr_cnt != wr0) begin n_mis++;
            $display("FAIL err_after: valid=%b strobes=%0d required 0/0", rsp_valid, rd_cnt - rd0 + wr_cnt - wr0); end
        $display("rejected size=%0d addr=%h", size, addr);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'h0;
        tick(); tick(); tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_mis++;
            $display("FAIL rst_ready: got %b required 0", req_ready); end
        n_cmp++; if (memory_as_ !== 1'b1 || memory_rw !== 1'b1 || memory_addr !== '0 || memory_wr_data !== 32'd0) begin n_mis++;
            $display("FAIL rst_bus: as_=%b rw=%b addr=%h wdata=%h required 1/1/0/0", memory_as_, memory_rw, memory_addr, memory_wr_data); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin n_mis++;
            $display("FAIL rst_rsp: valid=%b err=%b rdata=%h required 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_mis++;
            $display("FAIL rst_release_ready: got %b required 1", req_ready); end
        $display("reset done");
    endtask

    task automatic test_word_store_load();
        word_store(32'h10, 32'h35DF_0DB3);
        do_load(2'b10, 1'b0, 32'h10, 32'h35DF_0DB3);
    endtask

    task automatic test_byte_half_loads();
        word_store(32'h0, 32'h80FF_7F01);
        do_load(2'b00, 1'b0, 32'h0, 32'h0000_0001);
        do_load(2'b00, 1'b0, 32'h1, 32'h0000_007F);
        do_load(2'b00, 1'b0, 32'h2, 32'hFFFF_FFFF);
        do_load(2'b00, 1'b0, 32'h3, 32'hFFFF_FF80);
        do_load(2'b00, 1'b1, 32'h2, 32'h0000_00FF);
        do_load(2'b01, 1'b0, 32'h2, 32'hFFFF_80FF);
        do_load(2'b01, 1'b1, 32'h0, 32'h0000_7F01);
    endtask

    task automatic test_subword_store();
        word_store(32'h20, 32'h1122_3344);
        sub_store(2'b00, 32'h21, 32'h1234_56AA, 32'h1122_AA44);
        sub_store(2'b01, 32'h22, 32'h5555_BEEF, 32'hBEEF_AA44);
    endtask

    task automatic test_misaligned();
        bad_req(1'b0, 2'b01, 32'h3);
        bad_req(1'b0, 2'b10, 32'h6);
        bad_req(1'b1, 2'b11, 32'h0);
    endtask

    task automatic test_reset_mid_rmw();
        int wr0;
        logic saw_rsp;
        word_store(32'h30, 32'hCAFE_F00D);
        wr0 = wr_cnt;
        saw_rsp = 1'b0;
        issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_0077);   // now in RMW_RD
        tick();                                            // now in RMW_DATA
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || memory_as_ !== 1'b1) begin n_mis++;
            $display("FAIL rstmid_idle: ready=%b as_=%b required 1/1", req_ready, memory_as_); end
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
            tick();
        end
        n_cmp++; if (saw_rsp !== 1'b0) begin n_mis++;
            $display("FAIL rstmid_rsp: rsp_valid pulsed=%b required 0", saw_rsp); end
        n_cmp++; if (wr_cnt != wr0 || mem[12] !== 32'hCAFE_F00D) begin n_mis++;
            $display("FAIL rstmid_mem: writes=%0d word=%h required 0/cafef00d", wr_cnt - wr0, mem[12]); end
        $display("reset during RMW_DATA, word=%h", mem[12]);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int rsp[$];
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10;
        for (int c = 0; c < 16; c++) begin
            if (req_valid && req_ready) acc.push_back(c);
            if (rsp_valid === 1'b1) begin
                rsp.push_back(c);
                n_cmp++; if (rsp_rdata !== 32'h35DF_0DB3) begin n_mis++;
                    $display("FAIL b2b_rdata: got %h required 35df0db3", rsp_rdata); end
                $display("b2b response cycle=%0d rdata=%h", c, rsp_rdata);
            end
            tick();
            if (acc.size() == 4) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        n_cmp++; if (acc.size() != 4 || rsp.size() != 4) begin n_mis++;
            $display("FAIL b2b_count: accepts=%0d responses=%0d required 4/4", acc.size(), rsp.size()); end
        if (acc.size() == 4 && rsp.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++; if (acc[i] - acc[i-1] != 3) begin n_mis++;
                    $display("FAIL b2b_spacing: accept %0d gap=%0d required 3", i, acc[i] - acc[i-1]); end
                n_cmp++; if (rsp[i-1] != acc[i]) begin n_mis++;
                    $display("FAIL b2b_overlap: rsp cycle=%0d accept cycle=%0d required equal", rsp[i-1], acc[i]); end
            end
            n_cmp++; if (rsp[3] != acc[3] + 3) begin n_mis++;
                $display("FAIL b2b_last: rsp cycle=%0d required %0d", rsp[3], acc[3] + 3); end
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_half_loads();
        test_subword_store();
        test_misaligned();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
